// File: rtl/decode_stage_pipe.sv
// Registered instruction-decode stage with valid/ready handshakes on both sides and a
// per-register load-use scoreboard that holds any reader of an in-flight LOAD destination.
module decode_stage_pipe #(
    parameter int RAW       = 3,
    parameter int LOAD_LAT  = 1,
    parameter int ACC0_ADDR = 0,
    parameter int ACC1_ADDR = 1,
    parameter int DST_ADDR  = 2,
    parameter int STALL_CW  = 16,
    localparam int IW       = 2*RAW+3,
    localparam int NUM_REGS = 2**RAW
) (
    input  logic                i_clk,
    input  logic                i_reset,        // synchronous, active-low
    input  logic                i_flush,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [IW-1:0]       i_instruction,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic                o_reg_write_en,
    output logic                o_immediate_en,
    output logic                o_data_write_en,
    output logic                o_data_read_en,
    output logic                o_select_data,
    output logic [RAW-1:0]      o_reg_write_address,
    output logic [RAW-1:0]      o_reg_read_address_0,
    output logic [RAW-1:0]      o_reg_read_address_1,
    output logic [RAW-1:0]      o_immediate,
    output logic                o_hazard,
    output logic [STALL_CW-1:0] o_stall_cycles
);

    localparam logic [1:0]     K_MOVE  = 2'd0;
    localparam logic [1:0]     K_FLAG  = 2'd1;
    localparam logic [1:0]     K_LOAD  = 2'd2;
    localparam logic [1:0]     K_STORE = 2'd3;
    localparam logic [RAW-1:0] K_CMP   = RAW'(6);

    logic           w_is_alu;
    logic [1:0]     w_subop;
    logic           w_imm_bit;
    logic [RAW-1:0] w_field_a;
    logic [RAW-1:0] w_field_b;

    assign w_is_alu  = i_instruction[IW-1];
    assign w_subop   = i_instruction[IW-2 -: 2];
    assign w_imm_bit = i_instruction[IW-2];
    assign w_field_a = i_instruction[2*RAW-1 -: RAW];
    assign w_field_b = i_instruction[RAW-1:0];

    logic           w_dec_we;
    logic           w_dec_ie;
    logic           w_dec_dwe;
    logic           w_dec_dre;
    logic           w_dec_sd;
    logic [RAW-1:0] w_dec_wa;
    logic [RAW-1:0] w_dec_ra0;
    logic [RAW-1:0] w_dec_ra1;
    logic           w_src0_en;
    logic           w_src1_en;
    logic [RAW-1:0] w_src0;
    logic [RAW-1:0] w_src1;

    // Control bundle plus the set of registers the instruction actually reads.
    always_comb begin
        w_dec_we  = 1'b0;
        w_dec_ie  = 1'b0;
        w_dec_dwe = 1'b0;
        w_dec_dre = 1'b0;
        w_dec_sd  = 1'b0;
        w_dec_wa  = '0;
        w_dec_ra0 = '0;
        w_dec_ra1 = '0;
        w_src0_en = 1'b0;
        w_src1_en = 1'b0;
        w_src0    = '0;
        w_src1    = '0;
        if (w_is_alu) begin
            w_dec_we  = (w_field_a != K_CMP);
            w_dec_ie  = w_imm_bit;
            w_dec_ra0 = RAW'(ACC0_ADDR);
            w_dec_ra1 = RAW'(ACC1_ADDR);
            w_dec_wa  = RAW'(DST_ADDR);
            w_src0_en = 1'b1;
            w_src0    = RAW'(ACC0_ADDR);
            w_src1_en = !w_imm_bit;
            w_src1    = RAW'(ACC1_ADDR);
        end else begin
            case (w_subop)
                K_MOVE, K_FLAG: begin
                    w_dec_we  = 1'b1;
                    w_dec_ra1 = w_field_a;
                    w_dec_wa  = w_field_b;
                    w_src0_en = 1'b1;
                    w_src0    = w_field_a;
                end
                K_LOAD: begin
                    w_dec_we  = 1'b1;
                    w_dec_dre = 1'b1;
                    w_dec_sd  = 1'b1;
                    w_dec_wa  = w_field_a;
                    w_dec_ra0 = w_field_b;
                    w_src0_en = 1'b1;
                    w_src0    = w_field_b;
                end
                K_STORE: begin
                    w_dec_dwe = 1'b1;
                    w_dec_ra0 = w_field_b;
                    w_dec_ra1 = w_field_a;
                    w_src0_en = 1'b1;
                    w_src0    = w_field_a;
                    w_src1_en = 1'b1;
                    w_src1    = w_field_b;
                end
                default: ;
            endcase
        end
    end

    logic                r_valid;
    logic                r_we;
    logic                r_ie;
    logic                r_dwe;
    logic                r_dre;
    logic                r_sd;
    logic [RAW-1:0]      r_wa;
    logic [RAW-1:0]      r_ra0;
    logic [RAW-1:0]      r_ra1;
    logic [RAW-1:0]      r_imm;
    logic [STALL_CW-1:0] r_stall;

    logic                w_advance;
    logic                w_hazard;
    logic                w_accept;
    logic                w_load_issue;
    logic [NUM_REGS-1:0] w_pending;

    assign w_advance    = !r_valid || i_out_ready;
    assign w_hazard     = i_in_valid &&
                          ((w_src0_en && w_pending[w_src0]) || (w_src1_en && w_pending[w_src1]));
    assign o_in_ready   = w_advance && !w_hazard && !i_flush && i_reset;
    assign w_accept     = i_in_valid && o_in_ready;
    assign w_load_issue = w_accept && !w_is_alu && (w_subop == K_LOAD);

    // One issue-slot countdown per register; slots only elapse when the stage advances.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            logic [2:0] r_cnt;
            always_ff @(posedge i_clk) begin
                if (!i_reset || i_flush) begin
                    r_cnt <= 3'd0;
                end else if (w_advance) begin
                    if (w_load_issue && (w_dec_wa == RAW'(gi))) begin
                        r_cnt <= 3'(LOAD_LAT);
                    end else if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
            end
            assign w_pending[gi] = (r_cnt != 3'd0);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush || (w_advance && !w_accept)) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_ie    <= 1'b0;
            r_dwe   <= 1'b0;
            r_dre   <= 1'b0;
            r_sd    <= 1'b0;
            r_wa    <= '0;
            r_ra0   <= '0;
            r_ra1   <= '0;
            r_imm   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_we    <= w_dec_we;
            r_ie    <= w_dec_ie;
            r_dwe   <= w_dec_dwe;
            r_dre   <= w_dec_dre;
            r_sd    <= w_dec_sd;
            r_wa    <= w_dec_wa;
            r_ra0   <= w_dec_ra0;
            r_ra1   <= w_dec_ra1;
            r_imm   <= w_field_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_stall <= '0;
        end else if (w_hazard && !i_flush && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_CW'(1);
        end
    end

    assign o_out_valid          = r_valid;
    assign o_reg_write_en       = r_we;
    assign o_immediate_en       = r_ie;
    assign o_data_write_en      = r_dwe;
    assign o_data_read_en       = r_dre;
    assign o_select_data        = r_sd;
    assign o_reg_write_address  = r_wa;
    assign o_reg_read_address_0 = r_ra0;
    assign o_reg_read_address_1 = r_ra1;
    assign o_immediate          = r_imm;
    assign o_hazard             = w_hazard;
    assign o_stall_cycles       = r_stall;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios then random traffic, every cycle checked
// against a slot-numbered reference model of decode, handshake and load-use timing.
module tb_decode_stage_pipe;

    localparam int RAW  = 3;
    localparam int IW   = 2*RAW+3;
    localparam int NREG = 8;
    localparam int LAT  = 2;
    localparam int SCW  = 3;
    localparam int SMAX = 7;

    localparam logic [1:0] D_MOVE  = 2'd0;
    localparam logic [1:0] D_LOAD  = 2'd2;
    localparam logic [1:0] D_STORE = 2'd3;
    localparam logic [2:0] F_ADD   = 3'd0;
    localparam logic [2:0] F_CMP   = 3'd6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, flush, in_valid, out_ready;
    logic [IW-1:0]  instr;
    logic           in_ready, out_valid, we, ie, dwe, dre, sd, hazard;
    logic [2:0]     wa, ra0, ra1, imm;
    logic [SCW-1:0] stall;

    decode_stage_pipe #(
        .RAW(RAW), .LOAD_LAT(LAT), .ACC0_ADDR(0), .ACC1_ADDR(1), .DST_ADDR(2), .STALL_CW(SCW)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_instruction(instr),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_reg_write_en(we), .o_immediate_en(ie), .o_data_write_en(dwe),
        .o_data_read_en(dre), .o_select_data(sd),
        .o_reg_write_address(wa), .o_reg_read_address_0(ra0), .o_reg_read_address_1(ra1),
        .o_immediate(imm), .o_hazard(hazard), .o_stall_cycles(stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: slot = number of advance cycles so far; a register is readable once slot >= ready_slot.
    int         slot = 0;
    int         ready_slot [NREG];
    int         exp_stall = 0;
    bit         model_on = 1'b0;
    bit         fields_known = 1'b0;
    logic [5:0] exp_ctrl = '0;     // {valid, we, imm_en, dwe, dre, sel}
    logic [11:0] exp_fields = '0;  // {wa, ra0, ra1, imm}

    bit            acc;
    bit            have;
    int            s0;
    logic [IW-1:0] cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [IW-1:0] mk_data(input logic [1:0] sub, input logic [2:0] a, input logic [2:0] b);
        return {1'b0, sub, a, b};
    endfunction

    function automatic logic [IW-1:0] mk_alu(input logic immb, input logic [2:0] f, input logic [2:0] v);
        return {1'b1, immb, 1'b0, f, v};
    endfunction

    function automatic bit busy(input logic [2:0] r);
        return ready_slot[r] > slot;
    endfunction

    function automatic bit blocked(input logic [IW-1:0] ins);
        if (ins[8]) return busy(3'd0) || (!ins[7] && busy(3'd1));
        case (ins[7:6])
            D_LOAD:  return busy(ins[2:0]);
            D_STORE: return busy(ins[5:3]) || busy(ins[2:0]);
            default: return busy(ins[5:3]);
        endcase
    endfunction

    function automatic logic [17:0] ref_bundle(input logic [IW-1:0] ins);
        logic [2:0] a, b, e_wa, e_ra0, e_ra1;
        logic e_we, e_ie, e_dwe, e_dre, e_sd;
        a = ins[5:3]; b = ins[2:0];
        e_wa = 3'd0; e_ra0 = 3'd0; e_ra1 = 3'd0;
        e_we = 1'b0; e_ie = 1'b0; e_dwe = 1'b0; e_dre = 1'b0; e_sd = 1'b0;
        if (ins[8]) begin
            e_we = (a != F_CMP); e_ie = ins[7];
            e_ra0 = 3'd0; e_ra1 = 3'd1; e_wa = 3'd2;
        end else if (ins[7:6] == D_LOAD) begin
            e_we = 1'b1; e_dre = 1'b1; e_sd = 1'b1; e_wa = a; e_ra0 = b;
        end else if (ins[7:6] == D_STORE) begin
            e_dwe = 1'b1; e_ra0 = b; e_ra1 = a;
        end else begin
            e_we = 1'b1; e_ra1 = a; e_wa = b;
        end
        return {1'b1, e_we, e_ie, e_dwe, e_dre, e_sd, e_wa, e_ra0, e_ra1, b};
    endfunction

    function automatic logic [IW-1:0] rand_instr();
        logic [IW-1:0] v;
        v = IW'($urandom);
        v[5:3] = 3'($urandom_range(0, 3));
        v[2:0] = 3'($urandom_range(0, 3));
        if (v[8] && ($urandom_range(0, 1) == 1)) v[5:3] = 3'($urandom_range(0, 7));
        return v;
    endfunction

    task automatic clear_sb();
        for (int r = 0; r < NREG; r++) ready_slot[r] = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, update model at posedge,
    // check registered outputs at the following negedge.
    task automatic cycle(input logic rn, input logic fl, input logic iv, input logic [IW-1:0] ins,
                         input logic ordy, output bit accepted);
        bit haz, adv, rdy;
        logic [17:0] dec;
        rst_n = rn; flush = fl; in_valid = iv; instr = ins; out_ready = ordy;
        #1;
        haz = iv && blocked(ins);
        adv = !exp_ctrl[5] || ordy;
        rdy = adv && !haz && !fl && rn;
        accepted = iv && rdy;
        if (model_on) begin
            chk("hazard", 32'(hazard), 32'(haz));
            chk("in_ready", 32'(in_ready), 32'(rdy));
        end
        @(posedge clk);
        if (!rn) begin
            exp_ctrl = '0; exp_fields = '0; fields_known = 1'b1; exp_stall = 0;
            clear_sb(); model_on = 1'b1;
        end else if (fl) begin
            exp_ctrl = '0; fields_known = 1'b0; clear_sb();
        end else begin
            if (haz && exp_stall < SMAX) exp_stall++;
            if (adv) begin
                if (accepted) begin
                    dec = ref_bundle(ins);
                    exp_ctrl = dec[17:12]; exp_fields = dec[11:0]; fields_known = 1'b1;
                    if (!ins[8] && ins[7:6] == D_LOAD) ready_slot[ins[5:3]] = slot + 1 + LAT;
                end else begin
                    exp_ctrl = '0; fields_known = 1'b0;
                end
                slot++;
            end
        end
        @(negedge clk);
        if (model_on) begin
            chk("ctrl", 32'({out_valid, we, ie, dwe, dre, sd}), 32'(exp_ctrl));
            if (fields_known) chk("fields", 32'({wa, ra0, ra1, imm}), 32'(exp_fields));
            chk("stall", 32'(stall), 32'(exp_stall));
        end
    endtask

    task automatic issue(input logic [IW-1:0] ins);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 16 && !a; k++) cycle(1'b1, 1'b0, 1'b1, ins, 1'b1, a);
        chk("issue_accept", 32'(a), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_sb();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        @(negedge clk);

        // Reset, then idle: everything zero and ready
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        chk("s1_ready", 32'(in_ready), 32'(1));
        chk("s1_outs", 32'({out_valid, we, ie, dwe, dre, sd, wa, ra0, ra1, imm}), 32'(0));

        // Back-to-back stream
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_MOVE, 3'd5, 3'd2), 1'b1, acc);
        chk("s2_move", 32'({we, ra1, wa}), 32'({1'b1, 3'd5, 3'd2}));
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_STORE, 3'd4, 3'd6), 1'b1, acc);
        chk("s2_store", 32'({dwe, we, ra0, ra1}), 32'({1'b1, 1'b0, 3'd6, 3'd4}));
        cycle(1'b1, 1'b0, 1'b1, mk_alu(1'b1, F_CMP, 3'd3), 1'b1, acc);
        chk("s2_cmp", 32'({we, ie, ra0, ra1, wa}), 32'({1'b0, 1'b1, 3'd0, 3'd1, 3'd2}));

        // Load-use stall: reader of r3 waits LAT slots
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_LOAD, 3'd3, 3'd1), 1'b1, acc);
        s0 = int'(stall);
        issue(mk_data(D_MOVE, 3'd3, 3'd0));
        chk("s3_stall", 32'(stall), 32'(s0 + LAT));

        // Independent ALU after LOAD, then reader of r2 held while downstream stalls
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_LOAD, 3'd2, 3'd0), 1'b1, acc);
        cycle(1'b1, 1'b0, 1'b1, mk_alu(1'b0, F_ADD, 3'd0), 1'b1, acc);
        chk("s4_nostall", 32'(acc), 32'(1));
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, mk_data(D_MOVE, 3'd2, 3'd7), 1'b0, acc);
        issue(mk_data(D_MOVE, 3'd2, 3'd7));
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, mk_alu(1'b1, F_ADD, 3'd5), 1'b0, acc);
        chk("s4_hold", 32'({out_valid, ra1, wa}), 32'({1'b1, 3'd2, 3'd7}));
        issue(mk_alu(1'b1, F_ADD, 3'd5));

        // Flush during a stall clears the scoreboard
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_LOAD, 3'd1, 3'd0), 1'b1, acc);
        cycle(1'b1, 1'b1, 1'b1, mk_data(D_STORE, 3'd1, 3'd7), 1'b1, acc);
        chk("s5_flush_valid", 32'(out_valid), 32'(0));
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_STORE, 3'd1, 3'd7), 1'b1, acc);
        chk("s5_accept", 32'(acc), 32'(1));

        // Self-addressed LOAD, reload of a pending register, then its reader
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_LOAD, 3'd1, 3'd1), 1'b1, acc);
        chk("self_load", 32'(acc), 32'(1));
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_LOAD, 3'd1, 3'd0), 1'b1, acc);
        chk("reload", 32'(acc), 32'(1));
        issue(mk_data(D_MOVE, 3'd1, 3'd3));

        // Stall counter saturation, then reset mid-stall
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_LOAD, 3'd4, 3'd0), 1'b1, acc);
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b1, 1'b0, 1'b1, mk_data(D_MOVE, 3'd4, 3'd5), 1'b0, acc);
            chk("s6_sat", 32'(stall), 32'((k < SMAX) ? k : SMAX));
        end
        cycle(1'b0, 1'b0, 1'b1, mk_data(D_MOVE, 3'd4, 3'd5), 1'b0, acc);
        chk("s6_reset", 32'({out_valid, we, ie, dwe, dre, sd, wa, ra0, ra1, imm, stall}), 32'(0));
        cycle(1'b1, 1'b0, 1'b1, mk_data(D_MOVE, 3'd4, 3'd5), 1'b1, acc);
        chk("s6_after_reset", 32'(acc), 32'(1));

        // Random traffic; fetch holds an instruction until it is taken
        have = 1'b0; cur = '0;
        for (int i = 0; i < 800; i++) begin
            if (!have) begin
                have = ($urandom_range(0, 9) < 7);
                cur  = rand_instr();
            end
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0), have, cur,
                  ($urandom_range(0, 9) < 7), acc);
            if (acc) have = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
